rbus_d2r_dev_tx: RTL
====================

// Module: rbus_d2r_dev_tx
// PURPOSE
// - Device-side ring-bus transmitter: the requesting end of the d2r manager protocol.
// - Buffers one packet from a local device and posts a priority request in ctrl of a ring data word (sof=0).
// - Waits for a grant header (sof=1) carrying its DEV_ID, then overwrites that slot with the buffered packet.
// - Sits in series on one ring segment; every word not modified passes through with 1-cycle latency.
// PARAMETERS
// - DEV_ID       8'h01  device id placed in requests and matched against grants
// - REQ_TIMEOUT  256    cycles without a grant before the request is re-posted (the manager may drop it on fifo full)
// - SHORT_LEN    2      words per short slot, header included
// - LONG_LEN     9      words per long slot, header included (buffer depth)
// PORTS
// - clk      in   1   clock
// - rst      in   1   reset: synchronous, active-low
// - i_sof    in   1   ring in, start of slot (header word)
// - i_ctrl   in   12  ring in ctrl. sof=0: {req_v,prio[1:0],long,id[7:0]}; sof=1: {gnt_v,long,2'b0,id[7:0]}
// - i_data   in   72  ring in data. On the header, bit71=slot occupied
// - o_sof    out  1   ring out, registered
// - o_ctrl   out  12  ring out, registered
// - o_data   out  72  ring out, registered
// - tx_wr    in   1   device write strobe, honoured only while tx_rdy=1
// - tx_data  in   72  packet word; word 0 is the header (bit71 forced to 1 on insert)
// - tx_last  in   1   last word of the packet
// - tx_prio  in   2   priority, sampled with word 0; 3=highest
// - tx_rdy   out  1   buffer can accept a word
// - tx_done  out  1   1-cycle pulse after the last packet word leaves on o_*
// - tx_err   out  1   sticky: packet exceeded LONG_LEN words; cleared by reset only
// BEHAVIOUR
// - Reset (rst=0 at a clk edge): o_sof=0, o_ctrl=0, o_data=0, tx_rdy=1, tx_done=0, tx_err=0, FSM=IDLE, counters=0.
// - Default path: o_* <= i_* every cycle (latency 1), including during reset release.
// - FSM states:
//   - IDLE -> LOAD on tx_wr.
//   - LOAD: store words at wptr++. Exit to REQ on tx_wr&tx_last, or when the 9th word is written.
//     - If the 9th word lacks tx_last: set tx_err; the packet is truncated to 9 words and still sent.
//     - kind = long if word count > SHORT_LEN, else short. tx_rdy=1 only in IDLE and LOAD.
//   - REQ: wait for a cycle with i_sof=0 and i_ctrl[11]=0 (free request field).
//     - In that cycle o_ctrl <= {1,prio,kind,DEV_ID}; data passes unchanged. Then go to WAIT, timer=0.
//     - Occupied request fields (req_v=1) pass untouched; no overwrite ever.
//   - WAIT: timer++ each cycle. A grant matches when i_sof=1 & i_ctrl[11]=1 & i_ctrl[7:0]=DEV_ID & i_ctrl[10]=kind & i_data[71]=0.
//     - On a match: o_sof=1, o_ctrl=0 (grant consumed), o_data=buf[0] with bit71=1; go to SEND, rptr=1.
//     - Grant with wrong kind or occupied slot: pass through unchanged, keep waiting.
//     - timer reaching REQ_TIMEOUT-1 with no match: go to REQ; the timer does not wrap.
//   - SEND: for the remaining slot words (SHORT_LEN or LONG_LEN total), o_data=buf[rptr] while rptr<count, else 72'h0.
//     - o_ctrl and o_sof pass through.
//     - Last slot word: pulse tx_done next cycle; go to IDLE.
//     - i_sof=1 arriving in SEND (malformed ring): set tx_err, abort to REQ (packet retained); that header passes through.
// - A grant for DEV_ID seen in IDLE/LOAD/REQ/SEND (stale or duplicate) passes through unchanged.
// - Reset mid-operation: the buffered packet is discarded, no partial slot is completed; the ring word in flight is lost.
// STRUCTURE
// - Shared package rbus_pkg: ctrl field offsets (REQ_V=11, PRIO=10:9, LONG=8, ID=7:0, GNT_V=11, GLONG=10).
// - Also in rbus_pkg: the OCC=71 data bit, and SHORT_LEN/LONG_LEN defaults.
// - One sub-module: rbus_pkt_buf (9x72 single-write, single-read register buffer with wptr/rptr/count).
// - FSM, timer and ring mux live in the top level.
// TESTING
// - Pass-through: idle device, random ring traffic -> o_* equals i_* delayed 1 cycle, bit-exact.
// - Short packet: 2 words, prio=2; free data word -> o_ctrl=12'hC01 (DEV_ID=1) on that word.
//   Then grant header ctrl=12'h801, data71=0 -> header replaced with bit71=1, o_ctrl=0, word1 sent, tx_done pulses.
// - Long packet of 5 words: grant with long=1 -> slot words 5..8 driven 0.
//   A prior grant with long=0 for DEV_ID is passed unchanged.
// - Busy request field: 3 data words with i_ctrl[11]=1 -> unchanged; request appears on the 4th, free word.
// - Timeout: no grant for REQ_TIMEOUT=16 cycles -> a second request is posted at the next free data word.
// - Overflow and reset: 10-word write -> tx_rdy drops after word 9, tx_err=1.
//   rst=0 during SEND -> o_*=0 next cycle, tx_rdy=1, tx_err=0.

Source files
------------

// File: rtl/rbus_pkg.sv
// Shared ring-bus definitions: ctrl field offsets, data flag bit,
// slot lengths, device FSM states and a request-word builder.
package rbus_pkg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 72;

    // ctrl on data words (sof=0)
    localparam int REQ_V   = 11;
    localparam int PRIO_HI = 10;
    localparam int PRIO_LO = 9;
    localparam int LONG    = 8;
    localparam int ID_HI   = 7;
    localparam int ID_LO   = 0;

    // ctrl on header words (sof=1)
    localparam int GNT_V = 11;
    localparam int GLONG = 10;

    // header data: slot occupied
    localparam int OCC = 71;

    localparam int SHORT_LEN_DEF = 2;
    localparam int LONG_LEN_DEF  = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT,
        SEND
    } tx_state_t;

    function automatic logic [CTRL_W-1:0] req_word(
        input logic [1:0] prio,
        input logic       long_k,
        input logic [7:0] id
    );
        logic [CTRL_W-1:0] w;
        w                  = '0;
        w[REQ_V]           = 1'b1;
        w[PRIO_HI:PRIO_LO] = prio;
        w[LONG]            = long_k;
        w[ID_HI:ID_LO]     = id;
        return w;
    endfunction

endpackage

// File: rtl/rbus_d2r_dev_tx_if.sv
// Ring segment plus device write port of the d2r transmitter.
// master: ring source / device side; slave: the transmitter.
interface rbus_d2r_dev_tx_if;
    import rbus_pkg::*;

    logic              i_sof;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              o_sof;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic [1:0]        tx_prio;
    logic              tx_rdy;
    logic              tx_done;
    logic              tx_err;

    modport master (
        output i_sof, i_ctrl, i_data,
        output tx_wr, tx_data, tx_last, tx_prio,
        input  o_sof, o_ctrl, o_data,
        input  tx_rdy, tx_done, tx_err
    );

    modport slave (
        input  i_sof, i_ctrl, i_data,
        input  tx_wr, tx_data, tx_last, tx_prio,
        output o_sof, o_ctrl, o_data,
        output tx_rdy, tx_done, tx_err
    );

endinterface

// File: rtl/rbus_pkt_buf.sv
// Packet buffer: DEPTH x W registers, one write and one read port.
// Ports: clk, rst (sync, low), clr, wr/wdata, rd_init/rd_inc, count, rptr, hdr, rdata.
module rbus_pkt_buf #(
    parameter int DEPTH = 9,
    parameter int W     = 72,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd_init,
    input  logic          rd_inc,
    output logic [CW-1:0] count,
    output logic [CW-1:0] rptr,
    output logic [W-1:0]  hdr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
            rptr  <= '0;
        end else begin
            if (wr && count < CW'(DEPTH))
                count <= count + 1'b1;
            if (rd_init)
                rptr <= CW'(1);
            else if (rd_inc)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && count < CW'(DEPTH))
            mem[count] <= wdata;
    end

    assign hdr = mem[0];

    // slot words past the packet end are padded with zero
    assign rdata = (rptr < count) ? mem[rptr] : '0;

endmodule

// File: rtl/rbus_d2r_dev_tx.sv
// d2r device transmitter: buffers one packet, requests a slot, fills the granted slot.
// Ports: clk, rst (sync, active-low), bus (ring in/out + device tx port, slave modport).
module rbus_d2r_dev_tx
    import rbus_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = 8'h01,
    parameter int         REQ_TIMEOUT = 256,
    parameter int         SHORT_LEN   = SHORT_LEN_DEF,
    parameter int         LONG_LEN    = LONG_LEN_DEF
) (
    input logic              clk,
    input logic              rst,
    rbus_d2r_dev_tx_if.slave bus
);

    localparam int CW = $clog2(LONG_LEN + 1);
    localparam int TW = $clog2(REQ_TIMEOUT + 1);

    tx_state_t         state;
    logic [TW-1:0]     timer;
    logic [1:0]        prio_q;
    logic              kind_q;
    logic              o_sof_q;
    logic [CTRL_W-1:0] o_ctrl_q;
    logic [DATA_W-1:0] o_data_q;
    logic              done_q;
    logic              err_q;

    logic [CW-1:0]     count;
    logic [CW-1:0]     rptr;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] hdr_occ;
    logic [DATA_W-1:0] rdata;

    logic tx_rdy;
    logic accept;
    logic last_wr;
    logic free_req;
    logic grant_hit;
    logic slot_last;
    logic buf_clr;
    logic rd_init;
    logic rd_inc;

    assign tx_rdy  = (state == IDLE) || (state == LOAD);
    assign accept  = tx_rdy && bus.tx_wr;
    // the LONG_LEN-th word closes the packet whether or not it is last
    assign last_wr = accept && (bus.tx_last || count == CW'(LONG_LEN - 1));

    assign free_req  = !bus.i_sof && !bus.i_ctrl[REQ_V];
    assign grant_hit = bus.i_sof
                    && bus.i_ctrl[GNT_V]
                    && bus.i_ctrl[ID_HI:ID_LO] == DEV_ID
                    && bus.i_ctrl[GLONG] == kind_q
                    && !bus.i_data[OCC];

    assign slot_last = rptr == (kind_q ? CW'(LONG_LEN - 1)
                                       : CW'(SHORT_LEN - 1));

    assign rd_init = (state == WAIT) && grant_hit;
    assign rd_inc  = (state == SEND) && !bus.i_sof;
    assign buf_clr = rd_inc && slot_last;

    always_comb begin
        hdr_occ      = hdr;
        hdr_occ[OCC] = 1'b1;
    end

    rbus_pkt_buf #(
        .DEPTH (LONG_LEN),
        .W     (DATA_W),
        .CW    (CW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr      (accept),
        .wdata   (bus.tx_data),
        .rd_init (rd_init),
        .rd_inc  (rd_inc),
        .count   (count),
        .rptr    (rptr),
        .hdr     (hdr),
        .rdata   (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            prio_q   <= '0;
            kind_q   <= 1'b0;
            o_sof_q  <= 1'b0;
            o_ctrl_q <= '0;
            o_data_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            o_sof_q  <= bus.i_sof;
            o_ctrl_q <= bus.i_ctrl;
            o_data_q <= bus.i_data;
            done_q   <= 1'b0;
            unique case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (count == '0)
                            prio_q <= bus.tx_prio;
                        if (last_wr) begin
                            kind_q <= (int'(count) + 1) > SHORT_LEN;
                            if (!bus.tx_last)
                                err_q <= 1'b1;
                            state <= REQ;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                REQ: begin
                    if (free_req) begin
                        o_ctrl_q <= req_word(prio_q, kind_q, DEV_ID);
                        timer    <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (grant_hit) begin
                        o_sof_q  <= 1'b1;
                        o_ctrl_q <= '0;
                        o_data_q <= hdr_occ;
                        state    <= SEND;
                    end else if (timer == TW'(REQ_TIMEOUT - 1)) begin
                        state <= REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    // a header inside our slot means the ring is broken
                    if (bus.i_sof) begin
                        err_q <= 1'b1;
                        state <= REQ;
                    end else begin
                        o_data_q <= rdata;
                        if (slot_last) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_sof   = o_sof_q;
    assign bus.o_ctrl  = o_ctrl_q;
    assign bus.o_data  = o_data_q;
    assign bus.tx_rdy  = tx_rdy;
    assign bus.tx_done = done_q;
    assign bus.tx_err  = err_q;

endmodule
